// File: rtl/light_package.sv
// Shared lamp and phase types for the intersection controllers.
//   colors_e    : lamp drive code for one approach (red/yellow/green)
//   tlc_phase_e : controller phase (IDLE, GREEN, YELLOW, ALLRED)
//   lamp_color  : lamp code for one approach given the phase and whether
//                 that approach currently owns the phase
package light_package;

    localparam int COLOR_W = 2;

    typedef enum logic [COLOR_W-1:0] {
        COLOR_RED    = 2'd0,
        COLOR_YELLOW = 2'd1,
        COLOR_GREEN  = 2'd2
    } colors_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GREEN  = 2'd1,
        YELLOW = 2'd2,
        ALLRED = 2'd3
    } tlc_phase_e;

    // Only the owning approach may show a non-red aspect.
    function automatic colors_e lamp_color(input tlc_phase_e ph, input logic owner);
        colors_e c;
        c = COLOR_RED;
        if (owner == 1'b1) begin
            case (ph)
                GREEN:   c = COLOR_GREEN;
                YELLOW:  c = COLOR_YELLOW;
                default: c = COLOR_RED;
            endcase
        end else begin
            c = COLOR_RED;
        end
        return c;
    endfunction

endpackage

// File: rtl/tlc_rr_arbiter.sv
// Combinational round-robin picker.
// Scans ptr+1, ptr+2, ... (mod NUM_DIR) and returns the first requester.
//   req   : per-approach request vector
//   ptr   : last granted approach (lowest priority on this pick)
//   valid : at least one request present
//   grant : winning approach index (equals ptr when valid is low)
module tlc_rr_arbiter #(
    parameter int NUM_DIR = 3
) (
    input  logic [NUM_DIR-1:0]         req,
    input  logic [$clog2(NUM_DIR)-1:0] ptr,
    output logic                       valid,
    output logic [$clog2(NUM_DIR)-1:0] grant
);

    localparam int DIR_W = $clog2(NUM_DIR);

    logic hit_s;

    // Priority scan starting just after the previous winner.
    always_comb begin
        valid = 1'b0;
        grant = ptr;
        hit_s = 1'b0;
        for (int i = 1; i <= NUM_DIR; i++) begin
            hit_s = ~valid & req[DIR_W'((int'(ptr) + i) % NUM_DIR)];
            grant = hit_s ? DIR_W'((int'(ptr) + i) % NUM_DIR) : grant;
            valid = valid | hit_s;
        end
    end

endmodule

// File: rtl/traffic_light_controller_n.sv
// Parametrised N-approach traffic light controller.
// One phase FSM plus an owning-direction register; next green chosen by
// round-robin over the approaches currently requesting.
// Optional macro TLC_PREEMPT_EN adds emergency pre-emption inputs.
// Ports:
//   clk          : clock
//   reset_n      : synchronous active-low reset
//   sensor       : per-approach traffic present (bit d = approach d)
//   preempt_req  : (TLC_PREEMPT_EN only) emergency pre-emption request
//   preempt_dir  : (TLC_PREEMPT_EN only) approach to pre-empt to
//   light        : per-approach lamp code (colors_e), registered
//   active_dir   : approach owning green/yellow; last owner otherwise
//   phase        : current phase
module traffic_light_controller_n
    import light_package::*;
#(
    parameter int NUM_DIR    = 3,
    parameter int YELLOW_CYC = 2,
    parameter int ALLRED_CYC = 1,
    parameter int HOLD_CYC   = 5,
    parameter int MAX_CYC    = 10,
    parameter int CTR_W      = 8
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [NUM_DIR-1:0]                sensor,
`ifdef TLC_PREEMPT_EN
    input  logic                              preempt_req,
    input  logic [$clog2(NUM_DIR)-1:0]        preempt_dir,
`endif
    output logic [NUM_DIR-1:0][COLOR_W-1:0]   light,
    output logic [$clog2(NUM_DIR)-1:0]        active_dir,
    output tlc_phase_e                        phase
);

    localparam int DIR_W = $clog2(NUM_DIR);

    tlc_phase_e                      phase_r,     phase_nxt_s;
    logic [DIR_W-1:0]                dir_r,       dir_nxt_s;
    logic [DIR_W-1:0]                rr_ptr_r,    rr_ptr_nxt_s;
    logic [CTR_W-1:0]                hold_ctr_r,  hold_ctr_nxt_s;
    logic [CTR_W-1:0]                max_ctr_r,   max_ctr_nxt_s;
    logic [CTR_W-1:0]                phase_ctr_r, phase_ctr_nxt_s;
    logic                            hold_run_r,  hold_run_nxt_s;
    logic                            max_run_r,   max_run_nxt_s;
    logic [NUM_DIR-1:0][COLOR_W-1:0] light_r,     light_nxt_s;

    logic                            rr_valid_s;
    logic [DIR_W-1:0]                rr_grant_s;
    logic                            pick_valid_s;
    logic [DIR_W-1:0]                pick_dir_s;
    logic [DIR_W-1:0]                pick_ptr_s;
    logic [NUM_DIR-1:0]              own_mask_s;
    logic                            hold_cond_s;
    logic                            max_cond_s;
    logic [CTR_W-1:0]                hold_inc_s;
    logic [CTR_W-1:0]                max_inc_s;
    logic                            green_exit_s;
`ifdef TLC_PREEMPT_EN
    logic                            pre_valid_s;
`endif

    function automatic logic [CTR_W-1:0] sat_inc(input logic [CTR_W-1:0] v);
        return (&v) ? v : v + CTR_W'(1);
    endfunction

    tlc_rr_arbiter #(
        .NUM_DIR (NUM_DIR)
    ) u_rr_arbiter (
        .req   (sensor),
        .ptr   (rr_ptr_r),
        .valid (rr_valid_s),
        .grant (rr_grant_s)
    );

    // Green-phase run conditions: a flag, once set, keeps its counter running.
    assign own_mask_s   = {{(NUM_DIR-1){1'b0}}, 1'b1} << dir_r;
    assign hold_cond_s  = hold_run_r | ~sensor[dir_r];
    assign max_cond_s   = max_run_r | (|(sensor & ~own_mask_s));
    assign hold_inc_s   = hold_cond_s ? sat_inc(hold_ctr_r) : hold_ctr_r;
    assign max_inc_s    = max_cond_s  ? sat_inc(max_ctr_r)  : max_ctr_r;
    assign green_exit_s = (hold_cond_s && (hold_inc_s == CTR_W'(HOLD_CYC))) ||
                          (max_cond_s  && (max_inc_s  == CTR_W'(MAX_CYC)));

`ifdef TLC_PREEMPT_EN
    // Pre-emption overrides the round-robin pick but leaves rr_ptr alone.
    assign pre_valid_s  = preempt_req && (int'(preempt_dir) < NUM_DIR);
    assign pick_valid_s = pre_valid_s | rr_valid_s;
    assign pick_dir_s   = pre_valid_s ? preempt_dir : rr_grant_s;
    assign pick_ptr_s   = pre_valid_s ? rr_ptr_r    : rr_grant_s;
`else
    assign pick_valid_s = rr_valid_s;
    assign pick_dir_s   = rr_grant_s;
    assign pick_ptr_s   = rr_grant_s;
`endif

    // Next-state logic for the phase FSM, counters and round-robin pointer.
    always_comb begin
        phase_nxt_s     = phase_r;
        dir_nxt_s       = dir_r;
        rr_ptr_nxt_s    = rr_ptr_r;
        hold_ctr_nxt_s  = hold_ctr_r;
        max_ctr_nxt_s   = max_ctr_r;
        phase_ctr_nxt_s = phase_ctr_r;
        hold_run_nxt_s  = hold_run_r;
        max_run_nxt_s   = max_run_r;
        case (phase_r)
            IDLE: begin
                if (pick_valid_s) begin
                    phase_nxt_s    = GREEN;
                    dir_nxt_s      = pick_dir_s;
                    rr_ptr_nxt_s   = pick_ptr_s;
                    hold_ctr_nxt_s = {CTR_W{1'b0}};
                    max_ctr_nxt_s  = {CTR_W{1'b0}};
                    hold_run_nxt_s = 1'b0;
                    max_run_nxt_s  = 1'b0;
                end else begin
                    phase_nxt_s    = IDLE;
                end
            end
            GREEN: begin
`ifdef TLC_PREEMPT_EN
                if (pre_valid_s && (preempt_dir != dir_r)) begin
                    phase_nxt_s     = YELLOW;
                    phase_ctr_nxt_s = {CTR_W{1'b0}};
                end else if (pre_valid_s) begin
                    hold_ctr_nxt_s  = {CTR_W{1'b0}};
                    max_ctr_nxt_s   = {CTR_W{1'b0}};
                    hold_run_nxt_s  = 1'b0;
                    max_run_nxt_s   = 1'b0;
                end else
`endif
                begin
                    hold_ctr_nxt_s = hold_inc_s;
                    max_ctr_nxt_s  = max_inc_s;
                    hold_run_nxt_s = hold_cond_s;
                    max_run_nxt_s  = max_cond_s;
                    if (green_exit_s) begin
                        phase_nxt_s     = YELLOW;
                        phase_ctr_nxt_s = {CTR_W{1'b0}};
                    end else begin
                        phase_nxt_s     = GREEN;
                    end
                end
            end
            YELLOW: begin
                if (phase_ctr_r == CTR_W'(YELLOW_CYC - 1)) begin
                    phase_nxt_s     = ALLRED;
                    phase_ctr_nxt_s = {CTR_W{1'b0}};
                end else begin
                    phase_ctr_nxt_s = sat_inc(phase_ctr_r);
                end
            end
            ALLRED: begin
                if (phase_ctr_r == CTR_W'(ALLRED_CYC - 1)) begin
                    phase_ctr_nxt_s = {CTR_W{1'b0}};
                    if (pick_valid_s) begin
                        phase_nxt_s    = GREEN;
                        dir_nxt_s      = pick_dir_s;
                        rr_ptr_nxt_s   = pick_ptr_s;
                        hold_ctr_nxt_s = {CTR_W{1'b0}};
                        max_ctr_nxt_s  = {CTR_W{1'b0}};
                        hold_run_nxt_s = 1'b0;
                        max_run_nxt_s  = 1'b0;
                    end else begin
                        phase_nxt_s    = IDLE;
                    end
                end else begin
                    phase_ctr_nxt_s = sat_inc(phase_ctr_r);
                end
            end
            default: begin
                phase_nxt_s     = IDLE;
                phase_ctr_nxt_s = {CTR_W{1'b0}};
            end
        endcase
    end

    // Lamp codes are decoded from the next state so they register with it.
    always_comb begin
        light_nxt_s = {NUM_DIR{COLOR_RED}};
        for (int d = 0; d < NUM_DIR; d++) begin
            light_nxt_s[d] = lamp_color(phase_nxt_s, (DIR_W'(d) == dir_nxt_s));
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            phase_r     <= IDLE;
            dir_r       <= {DIR_W{1'b0}};
            rr_ptr_r    <= DIR_W'(NUM_DIR - 1);
            hold_ctr_r  <= {CTR_W{1'b0}};
            max_ctr_r   <= {CTR_W{1'b0}};
            phase_ctr_r <= {CTR_W{1'b0}};
            hold_run_r  <= 1'b0;
            max_run_r   <= 1'b0;
            light_r     <= {NUM_DIR{COLOR_RED}};
        end else begin
            phase_r     <= phase_nxt_s;
            dir_r       <= dir_nxt_s;
            rr_ptr_r    <= rr_ptr_nxt_s;
            hold_ctr_r  <= hold_ctr_nxt_s;
            max_ctr_r   <= max_ctr_nxt_s;
            phase_ctr_r <= phase_ctr_nxt_s;
            hold_run_r  <= hold_run_nxt_s;
            max_run_r   <= max_run_nxt_s;
            light_r     <= light_nxt_s;
        end
    end

    assign light      = light_r;
    assign active_dir = dir_r;
    assign phase      = phase_r;

endmodule

// File: tb/tb_traffic_light_controller_n.sv
// Scoreboard bench for traffic_light_controller_n.
// DUT A: default parameters. DUT B: NUM_DIR=4, YELLOW_CYC=3, ALLRED_CYC=2, HOLD_CYC=1.
// Stimulus pushes the hand-derived expected state for each driven cycle;
// per-DUT monitors pop and compare one cycle after the edge.
module tb_traffic_light_controller_n;
    import light_package::*;

    typedef struct {
        tlc_phase_e ph;
        int         dir;
    } exp_t;

    logic clk;
    logic reset_n_a, reset_n_b;
    logic [2:0] sensor_a;
    logic [3:0] sensor_b;
    logic       preempt_req_a, preempt_req_b;
    logic [1:0] preempt_dir_a, preempt_dir_b;
    logic [2:0][1:0] light_a;
    logic [3:0][1:0] light_b;
    logic [1:0] active_dir_a, active_dir_b;
    tlc_phase_e phase_a, phase_b;

    exp_t q_a[$];
    exp_t q_b[$];
    int checks = 0;
    int errors = 0;

    traffic_light_controller_n u_dut_a (
        .clk        (clk),
        .reset_n    (reset_n_a),
        .sensor     (sensor_a),
`ifdef TLC_PREEMPT_EN
        .preempt_req(preempt_req_a),
        .preempt_dir(preempt_dir_a),
`endif
        .light      (light_a),
        .active_dir (active_dir_a),
        .phase      (phase_a)
    );

    traffic_light_controller_n #(
        .NUM_DIR    (4),
        .YELLOW_CYC (3),
        .ALLRED_CYC (2),
        .HOLD_CYC   (1),
        .MAX_CYC    (10),
        .CTR_W      (8)
    ) u_dut_b (
        .clk        (clk),
        .reset_n    (reset_n_b),
        .sensor     (sensor_b),
`ifdef TLC_PREEMPT_EN
        .preempt_req(preempt_req_b),
        .preempt_dir(preempt_dir_b),
`endif
        .light      (light_b),
        .active_dir (active_dir_b),
        .phase      (phase_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string nm, input tlc_phase_e ph_act, input int dir_act,
                         input logic [7:0][1:0] lt, input int n, input exp_t e);
        logic [7:0][1:0] el;
        int nonred;
        el = '0;
        nonred = 0;
        for (int d = 0; d < n; d++) begin
            if (d == e.dir && e.ph == GREEN)       el[d] = COLOR_GREEN;
            else if (d == e.dir && e.ph == YELLOW) el[d] = COLOR_YELLOW;
            else                                   el[d] = COLOR_RED;
            if (lt[d] != COLOR_RED) nonred++;
        end
        checks++;
        if (ph_act !== e.ph) begin
            errors++;
            $display("FAIL %s phase got %0d want %0d at %0t", nm, ph_act, e.ph, $time);
        end
        checks++;
        if (dir_act !== e.dir) begin
            errors++;
            $display("FAIL %s active_dir got %0d want %0d at %0t", nm, dir_act, e.dir, $time);
        end
        checks++;
        if (lt !== el) begin
            errors++;
            $display("FAIL %s light got %h want %h at %0t", nm, lt, el, $time);
        end
        checks++;
        if (nonred > 1) begin
            errors++;
            $display("FAIL %s exclusive non-red count got %0d want <=1 at %0t", nm, nonred, $time);
        end
    endtask

    // Monitor for DUT A
    initial begin
        exp_t e;
        logic [7:0][1:0] lt;
        forever begin
            @(posedge clk);
            #1;
            if (q_a.size() > 0) begin
                e = q_a.pop_front();
                lt = '0;
                lt[2:0] = light_a;
                check("A", phase_a, int'(active_dir_a), lt, 3, e);
            end
        end
    end

    // Monitor for DUT B
    initial begin
        exp_t e;
        logic [7:0][1:0] lt;
        forever begin
            @(posedge clk);
            #1;
            if (q_b.size() > 0) begin
                e = q_b.pop_front();
                lt = '0;
                lt[3:0] = light_b;
                check("B", phase_b, int'(active_dir_b), lt, 4, e);
            end
        end
    end

    // One cycle of stimulus; the expectation is the state after the next edge.
    task automatic step(input bit b, input bit rst, input logic [3:0] s, input bit pr,
                        input logic [1:0] pd, input tlc_phase_e ph, input int dir);
        exp_t e;
        @(negedge clk);
        e.ph  = ph;
        e.dir = dir;
        if (!b) begin
            reset_n_a     = rst;
            sensor_a      = s[2:0];
            preempt_req_a = pr;
            preempt_dir_a = pd;
            q_a.push_back(e);
        end else begin
            reset_n_b     = rst;
            sensor_b      = s;
            preempt_req_b = pr;
            preempt_dir_b = pd;
            q_b.push_back(e);
        end
    endtask

    task automatic run(input bit b, input int n, input logic [3:0] s,
                       input tlc_phase_e ph, input int dir);
        for (int i = 0; i < n; i++) step(b, 1'b1, s, 1'b0, 2'd0, ph, dir);
    endtask

    task automatic do_reset(input bit b, input logic [3:0] s);
        for (int i = 0; i < 2; i++) step(b, 1'b0, s, 1'b0, 2'd0, IDLE, 0);
    endtask

    initial begin
        int guard;
        reset_n_a = 1'b0; reset_n_b = 1'b0;
        sensor_a = 3'd0;  sensor_b = 4'd0;
        preempt_req_a = 1'b0; preempt_req_b = 1'b0;
        preempt_dir_a = 2'd0; preempt_dir_b = 2'd0;

        // 1: single pulse on dir0 -> hold-limited green
        do_reset(1'b0, 4'b0000);
        run(1'b0, 1, 4'b0001, GREEN, 0);
        run(1'b0, 4, 4'b0000, GREEN, 0);
        run(1'b0, 2, 4'b0000, YELLOW, 0);
        run(1'b0, 1, 4'b0000, ALLRED, 0);
        run(1'b0, 3, 4'b0000, IDLE, 0);

        // 2: two-way contention -> max-limited alternation 0,1,0
        do_reset(1'b0, 4'b0011);
        for (int k = 0; k < 3; k++) begin
            run(1'b0, 10, 4'b0011, GREEN, k % 2);
            run(1'b0, 2, 4'b0011, YELLOW, k % 2);
            run(1'b0, 1, 4'b0011, ALLRED, k % 2);
        end

        // 3: all approaches requesting -> order 0,1,2,0
        do_reset(1'b0, 4'b0111);
        for (int k = 0; k < 3; k++) begin
            run(1'b0, 10, 4'b0111, GREEN, k);
            run(1'b0, 2, 4'b0111, YELLOW, k);
            run(1'b0, 1, 4'b0111, ALLRED, k);
        end
        run(1'b0, 10, 4'b0111, GREEN, 0);

        // 4: own traffic only holds green; conflict on dir2 ends it 10 cycles later
        do_reset(1'b0, 4'b0000);
        run(1'b0, 50, 4'b0001, GREEN, 0);
        run(1'b0, 9, 4'b0101, GREEN, 0);
        run(1'b0, 2, 4'b0101, YELLOW, 0);
        run(1'b0, 1, 4'b0101, ALLRED, 0);
        run(1'b0, 10, 4'b0101, GREEN, 2);
        run(1'b0, 1, 4'b0101, YELLOW, 2);

        // 6: reset in second yellow of dir1 aborts to IDLE; rr_ptr back to NUM_DIR-1
        do_reset(1'b0, 4'b0011);
        run(1'b0, 10, 4'b0011, GREEN, 0);
        run(1'b0, 2, 4'b0011, YELLOW, 0);
        run(1'b0, 1, 4'b0011, ALLRED, 0);
        run(1'b0, 10, 4'b0011, GREEN, 1);
        run(1'b0, 2, 4'b0011, YELLOW, 1);
        step(1'b0, 1'b0, 4'b0011, 1'b0, 2'd0, IDLE, 0);
        // pointer at 2 selects dir1 first out of {1,2}
        run(1'b0, 4, 4'b0110, GREEN, 1);

`ifdef TLC_PREEMPT_EN
        // preempt to dir2 during dir0 green
        do_reset(1'b0, 4'b0000);
        run(1'b0, 3, 4'b0001, GREEN, 0);
        step(1'b0, 1'b1, 4'b0001, 1'b1, 2'd2, YELLOW, 0);
        step(1'b0, 1'b1, 4'b0001, 1'b1, 2'd2, YELLOW, 0);
        step(1'b0, 1'b1, 4'b0001, 1'b1, 2'd2, ALLRED, 0);
        step(1'b0, 1'b1, 4'b0001, 1'b1, 2'd2, GREEN, 2);
        step(1'b0, 1'b1, 4'b0001, 1'b1, 2'd2, GREEN, 2);
        run(1'b0, 2, 4'b0001, GREEN, 2);
`endif

        // 5: alternate parameters, single pulse on dir3
        do_reset(1'b1, 4'b0000);
        run(1'b1, 1, 4'b1000, GREEN, 3);
        run(1'b1, 3, 4'b0000, YELLOW, 3);
        run(1'b1, 2, 4'b0000, ALLRED, 3);
        run(1'b1, 3, 4'b0000, IDLE, 3);

        guard = 0;
        while ((q_a.size() > 0 || q_b.size() > 0) && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        @(posedge clk);
        #2;
        checks++;
        if (q_a.size() > 0 || q_b.size() > 0) begin
            errors++;
            $display("FAIL drain queues got %0d/%0d entries want 0/0", q_a.size(), q_b.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
